// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, ID-resolved branch flushes, DMEM freeze with watchdog.
// Controls are combinational (same-edge effect); state, watchdog and perf counters are registered. No backpressure of its own.
module hazard_stall_controller #(
    parameter int MAX_MEM_WAIT = 15,
    parameter int CNT_W        = 16
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Rt,
    input  logic             BranchTaken,
    input  logic             Jump,
    input  logic             DMEM_Busy,
    output logic             STALL_PC,
    output logic             STALL_IFID,
    output logic             FLUSH_IFID,
    output logic             FLUSH_IDEX,
    output logic             STALL_IDEX,
    output logic             STALL_EXMEM,
    output logic             MemTimeout,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        ERROR   = 2'd2
    } state_t;

    localparam logic [7:0] MAX_WAIT = 8'(MAX_MEM_WAIT);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic hold_all;

    assign load_use = EX_MemRead && (EX_Rt != 5'd0) &&
                      ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

    // Any state other than RUN/MEMWAIT (ERROR or the unused encoding) freezes unconditionally.
    assign hold_all = ((state_q != RUN) && (state_q != MEMWAIT)) || DMEM_Busy;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q       <= RUN;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            RUN: begin
                if (DMEM_Busy) begin
                    state_d    = MEMWAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MEMWAIT: begin
                if (!DMEM_Busy) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q < MAX_WAIT) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end else begin
                    state_d       = ERROR;
                    mem_timeout_d = 1'b1;
                end
            end
            default: begin
                state_d       = ERROR;
                mem_timeout_d = 1'b1;
            end
        endcase
    end

    always_comb begin
        STALL_PC    = 1'b0;
        STALL_IFID  = 1'b0;
        FLUSH_IFID  = 1'b0;
        FLUSH_IDEX  = 1'b0;
        STALL_IDEX  = 1'b0;
        STALL_EXMEM = 1'b0;
        if (hold_all) begin
            STALL_PC    = 1'b1;
            STALL_IFID  = 1'b1;
            STALL_IDEX  = 1'b1;
            STALL_EXMEM = 1'b1;
        end else if (load_use) begin
            // Branch/jump is deliberately dropped here; it re-resolves next cycle with forwarded operands.
            STALL_PC   = 1'b1;
            STALL_IFID = 1'b1;
            FLUSH_IDEX = 1'b1;
        end else if (BranchTaken || Jump) begin
            FLUSH_IFID = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (STALL_PC && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (FLUSH_IFID && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    assign MemTimeout = mem_timeout_q;
    assign State      = state_q;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed self-checking bench for hazard_stall_controller (narrow counters so saturation is reachable).
module tb_hazard_stall_controller;

    localparam int CNT_W = 4;

    logic             CLOCK;
    logic             RESET;
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic             ID_UsesRt;
    logic             EX_MemRead;
    logic [4:0]       EX_Rt;
    logic             BranchTaken;
    logic             Jump;
    logic             DMEM_Busy;
    logic             STALL_PC;
    logic             STALL_IFID;
    logic             FLUSH_IFID;
    logic             FLUSH_IDEX;
    logic             STALL_IDEX;
    logic             STALL_EXMEM;
    logic             MemTimeout;
    logic [1:0]       State;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;
    logic [5:0]       ctl;

    int vectors;
    int miscompares;

    hazard_stall_controller #(.MAX_MEM_WAIT(15), .CNT_W(CNT_W)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
        .BranchTaken(BranchTaken), .Jump(Jump), .DMEM_Busy(DMEM_Busy),
        .STALL_PC(STALL_PC), .STALL_IFID(STALL_IFID), .FLUSH_IFID(FLUSH_IFID),
        .FLUSH_IDEX(FLUSH_IDEX), .STALL_IDEX(STALL_IDEX), .STALL_EXMEM(STALL_EXMEM),
        .MemTimeout(MemTimeout), .State(State),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    // {STALL_PC, STALL_IFID, FLUSH_IFID, FLUSH_IDEX, STALL_IDEX, STALL_EXMEM}
    assign ctl = {STALL_PC, STALL_IFID, FLUSH_IFID, FLUSH_IDEX, STALL_IDEX, STALL_EXMEM};

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic set_idle();
        ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0;
        EX_MemRead = 1'b0; EX_Rt = 5'd0;
        BranchTaken = 1'b0; Jump = 1'b0; DMEM_Busy = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        set_idle();
        RESET = 1'b0;
        @(negedge CLOCK);
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++; if (State !== 2'd0) begin miscompares++; $display("FAIL rst_state: got %0d want 0", State); end
        vectors++; if (MemTimeout !== 1'b0) begin miscompares++; $display("FAIL rst_timeout: got %b want 0", MemTimeout); end
        vectors++; if (ctl !== 6'b000000) begin miscompares++; $display("FAIL rst_ctl: got %b want 000000", ctl); end
        vectors++; if ({StallCount, FlushCount} !== 8'h00) begin miscompares++; $display("FAIL rst_counts: got %0d/%0d want 0/0", StallCount, FlushCount); end
    endtask

    task automatic test_reset_mid_memwait();
        do_reset();
        DMEM_Busy = 1'b1;
        repeat (5) @(posedge CLOCK);
        #1;
        vectors++; if (State !== 2'd1) begin miscompares++; $display("FAIL mid_pre_state: got %0d want 1", State); end
        @(negedge CLOCK);
        set_idle();
        RESET = 1'b0;
        #1;
        vectors++; if (State !== 2'd0) begin miscompares++; $display("FAIL mid_state: got %0d want 0", State); end
        vectors++; if (MemTimeout !== 1'b0) begin miscompares++; $display("FAIL mid_timeout: got %b want 0", MemTimeout); end
        vectors++; if (StallCount !== 4'd0) begin miscompares++; $display("FAIL mid_stallcnt: got %0d want 0", StallCount); end
        vectors++; if (ctl !== 6'b000000) begin miscompares++; $display("FAIL mid_ctl: got %b want 000000", ctl); end
        @(negedge CLOCK);
        RESET = 1'b1;
    endtask

    task automatic test_load_use();
        do_reset();
        EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8;
        #1;
        vectors++; if (ctl !== 6'b110100) begin miscompares++; $display("FAIL lu_ctl: got %b want 110100", ctl); end
        @(negedge CLOCK);
        EX_MemRead = 1'b0;
        #1;
        vectors++; if (ctl !== 6'b000000) begin miscompares++; $display("FAIL lu_after_ctl: got %b want 000000", ctl); end
        vectors++; if (StallCount !== 4'd1) begin miscompares++; $display("FAIL lu_stallcnt: got %0d want 1", StallCount); end
        vectors++; if (FlushCount !== 4'd0) begin miscompares++; $display("FAIL lu_flushcnt: got %0d want 0", FlushCount); end
    endtask

    task automatic test_no_false_hazard();
        do_reset();
        EX_MemRead = 1'b1; EX_Rt = 5'd0; ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b1;
        #1;
        vectors++; if (ctl !== 6'b000000) begin miscompares++; $display("FAIL nf_r0: got %b want 000000", ctl); end
        EX_Rt = 5'd9; ID_Rt = 5'd9; ID_Rs = 5'd3; ID_UsesRt = 1'b0;
        #1;
        vectors++; if (ctl !== 6'b000000) begin miscompares++; $display("FAIL nf_rt_unused: got %b want 000000", ctl); end
        ID_UsesRt = 1'b1;
        #1;
        vectors++; if (ctl !== 6'b110100) begin miscompares++; $display("FAIL nf_rt_used: got %b want 110100", ctl); end
        EX_MemRead = 1'b0;
        #1;
        vectors++; if (ctl !== 6'b000000) begin miscompares++; $display("FAIL nf_noload: got %b want 000000", ctl); end
    endtask

    task automatic test_load_use_branch();
        do_reset();
        EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8; BranchTaken = 1'b1;
        #1;
        vectors++; if (ctl !== 6'b110100) begin miscompares++; $display("FAIL lub_ctl: got %b want 110100", ctl); end
        @(negedge CLOCK);
        EX_MemRead = 1'b0;
        #1;
        vectors++; if (ctl !== 6'b001000) begin miscompares++; $display("FAIL lub_branch_ctl: got %b want 001000", ctl); end
        @(negedge CLOCK);
        BranchTaken = 1'b0; Jump = 1'b1;
        #1;
        vectors++; if (FlushCount !== 4'd1) begin miscompares++; $display("FAIL lub_flushcnt: got %0d want 1", FlushCount); end
        vectors++; if (ctl !== 6'b001000) begin miscompares++; $display("FAIL lub_jump_ctl: got %b want 001000", ctl); end
        @(negedge CLOCK);
        Jump = 1'b0;
        #1;
        vectors++; if ({StallCount, FlushCount} !== {4'd1, 4'd2}) begin miscompares++; $display("FAIL lub_counts: got %0d/%0d want 1/2", StallCount, FlushCount); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        DMEM_Busy = 1'b1;
        #1;
        vectors++; if (ctl !== 6'b110011) begin miscompares++; $display("FAIL mw_ctl_run: got %b want 110011", ctl); end
        vectors++; if (State !== 2'd0) begin miscompares++; $display("FAIL mw_state_run: got %0d want 0", State); end
        @(negedge CLOCK);
        EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8; BranchTaken = 1'b1;
        #1;
        vectors++; if (ctl !== 6'b110011) begin miscompares++; $display("FAIL mw_ctl_prio: got %b want 110011", ctl); end
        vectors++; if (State !== 2'd1) begin miscompares++; $display("FAIL mw_state_wait: got %0d want 1", State); end
        @(negedge CLOCK);
        @(negedge CLOCK);
        set_idle();
        BranchTaken = 1'b1;
        #1;
        vectors++; if (ctl !== 6'b001000) begin miscompares++; $display("FAIL mw_exit_ctl: got %b want 001000", ctl); end
        vectors++; if (State !== 2'd1) begin miscompares++; $display("FAIL mw_exit_state: got %0d want 1", State); end
        @(posedge CLOCK);
        #1;
        vectors++; if (State !== 2'd0) begin miscompares++; $display("FAIL mw_back_run: got %0d want 0", State); end
        vectors++; if (StallCount !== 4'd3) begin miscompares++; $display("FAIL mw_stallcnt: got %0d want 3", StallCount); end
        vectors++; if (FlushCount !== 4'd1) begin miscompares++; $display("FAIL mw_flushcnt: got %0d want 1", FlushCount); end
        vectors++; if (MemTimeout !== 1'b0) begin miscompares++; $display("FAIL mw_timeout: got %b want 0", MemTimeout); end
    endtask

    task automatic test_timeout();
        do_reset();
        DMEM_Busy = 1'b1;
        repeat (15) @(posedge CLOCK);
        #1;
        vectors++; if ({State, MemTimeout} !== {2'd1, 1'b0}) begin miscompares++; $display("FAIL to_15: got state %0d to %b want 1 0", State, MemTimeout); end
        @(posedge CLOCK);
        #1;
        vectors++; if (State !== 2'd2) begin miscompares++; $display("FAIL to_state: got %0d want 2", State); end
        vectors++; if (MemTimeout !== 1'b1) begin miscompares++; $display("FAIL to_flag: got %b want 1", MemTimeout); end
        vectors++; if (StallCount !== 4'd15) begin miscompares++; $display("FAIL to_stall_sat: got %0d want 15", StallCount); end
        @(negedge CLOCK);
        DMEM_Busy = 1'b0; Jump = 1'b1;
        #1;
        vectors++; if (ctl !== 6'b110011) begin miscompares++; $display("FAIL to_err_ctl: got %b want 110011", ctl); end
        @(posedge CLOCK);
        #1;
        vectors++; if ({State, MemTimeout} !== {2'd2, 1'b1}) begin miscompares++; $display("FAIL to_sticky: got state %0d to %b want 2 1", State, MemTimeout); end
        @(negedge CLOCK);
        set_idle();
        RESET = 1'b0;
        #1;
        vectors++; if ({State, MemTimeout, ctl} !== 9'd0) begin miscompares++; $display("FAIL to_reset: got state %0d to %b ctl %b want 0 0 000000", State, MemTimeout, ctl); end
        @(negedge CLOCK);
        RESET = 1'b1;
    endtask

    task automatic test_flush_saturation();
        do_reset();
        Jump = 1'b1;
        repeat (17) @(posedge CLOCK);
        #1;
        vectors++; if (FlushCount !== 4'd15) begin miscompares++; $display("FAIL sat_flushcnt: got %0d want 15", FlushCount); end
        vectors++; if (StallCount !== 4'd0) begin miscompares++; $display("FAIL sat_stallcnt: got %0d want 0", StallCount); end
        Jump = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        RESET = 1'b0;
        set_idle();
        test_reset();
        test_reset_mid_memwait();
        test_load_use();
        test_no_false_hazard();
        test_load_use_branch();
        test_mem_wait();
        test_timeout();
        test_flush_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline; drives the STALL/FLUSH inputs of the PC register, IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects load-use hazards and taken branches/jumps resolved in ID.
- Freezes the whole pipeline while the multi-cycle data memory is busy, with a timeout watchdog.
- Exposes stall/flush performance counters for the simulation display logic.

Parameters:
MAX_MEM_WAIT, 15, max consecutive DMEM_Busy cycles tolerated before timeout (1..255)
CNT_W, 16, width of performance counters

Ports:
CLOCK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-low reset
ID_Rs  in  5  source register rs of instruction in ID
ID_Rt  in  5  source register rt of instruction in ID
ID_UsesRt  in  1  ID instruction reads rt
EX_MemRead  in  1  instruction in EX is a load
EX_Rt  in  5  destination register of load in EX
BranchTaken  in  1  branch resolved taken in ID
Jump  in  1  jump decoded in ID
DMEM_Busy  in  1  data memory has not completed current access
STALL_PC  out  1  hold PC
STALL_IFID  out  1  hold IF/ID
FLUSH_IFID  out  1  zero IF/ID
FLUSH_IDEX  out  1  zero ID/EX (bubble)
STALL_IDEX  out  1  hold ID/EX
STALL_EXMEM  out  1  hold EX/MEM
MemTimeout  out  1  sticky memory-timeout error
State  out  2  FSM state: 0 RUN, 1 MEMWAIT, 2 ERROR
StallCount  out  CNT_W  cycles with STALL_PC=1, saturating
FlushCount  out  CNT_W  cycles with FLUSH_IFID=1, saturating

Behaviour:
- Control outputs are combinational (Mealy) from State and inputs, so they act at the same CLOCK edge. State, wait counter, MemTimeout and the performance counters are registered.
- Reset (RESET=0, async, any time incl. mid-MEMWAIT):
  - State=RUN, wait counter=0, MemTimeout=0, StallCount=0, FlushCount=0.
  - All control outputs 0 while in RUN with idle inputs.
- LoadUse = EX_MemRead && EX_Rt!=0 && (EX_Rt==ID_Rs || (ID_UsesRt && EX_Rt==ID_Rt)).
- Freeze = (State==RUN or MEMWAIT) && DMEM_Busy.
- Output priority:
  1. ERROR or Freeze: STALL_PC=STALL_IFID=STALL_IDEX=STALL_EXMEM=1; all flushes 0.
  2. Otherwise, LoadUse: STALL_PC=STALL_IFID=1, FLUSH_IDEX=1, FLUSH_IFID=0. Any branch/jump is ignored that cycle and re-resolves next cycle with correct operands.
  3. Otherwise, BranchTaken or Jump: FLUSH_IFID=1, everything else 0.
  4. Otherwise, all 0.
- FSM:
  - RUN: DMEM_Busy=1 -> MEMWAIT, wait counter <= 1.
  - MEMWAIT, DMEM_Busy=1, wait counter < MAX_MEM_WAIT: wait counter <= wait counter + 1, stay in MEMWAIT.
  - MEMWAIT, DMEM_Busy=1, wait counter == MAX_MEM_WAIT: -> ERROR, MemTimeout <= 1.
  - MEMWAIT, DMEM_Busy=0: -> RUN, wait counter <= 0. Priorities 2-4 apply in that exit cycle.
  - ERROR: absorbing until reset; pipeline frozen, MemTimeout=1.
- Load-use stall is inherently one cycle: the bubble clears EX_MemRead on the next edge.
- Counters:
  - StallCount increments on each edge where STALL_PC=1, including freeze cycles.
  - FlushCount increments on each edge where FLUSH_IFID=1.
  - Both saturate at 2^CNT_W-1 and do not wrap.
- Register 0 never causes a load-use stall.

Test Plan:
- Reset mid-operation: RESET=0 while State=MEMWAIT with wait counter=5 -> State=0, MemTimeout=0, counters 0, all controls 0 immediately (async).
- Load-use: EX_MemRead=1, EX_Rt=8, ID_Rs=8 -> exactly one cycle STALL_PC=STALL_IFID=FLUSH_IDEX=1; next cycle with EX_MemRead=0 -> all 0; StallCount=1.
- No false hazard: EX_Rt=0=ID_Rs, or EX_Rt=9=ID_Rt with ID_UsesRt=0 -> no stall.
- Load-use plus branch: LoadUse and BranchTaken=1 in the same cycle -> FLUSH_IFID=0 that cycle; next cycle BranchTaken=1 alone -> FLUSH_IFID=1, FlushCount=1.
- Memory wait: DMEM_Busy=1 for 3 cycles then 0 -> four stall outputs high for 3 cycles, State=1, back to RUN, StallCount=3, MemTimeout=0.
- Timeout: DMEM_Busy held 1 with MAX_MEM_WAIT=15 -> State=2 and MemTimeout=1 after the 16th busy edge. State stays 2 after DMEM_Busy drops, until reset.
